// File: rtl/max7219_rx.sv
// MAX7219 3-wire serial receiver: resynchronises load/din/clk, deserialises 16-bit
// words and latches the daisy-chain frame on every load rising edge.
module max7219_rx #(
   parameter int G_NB_DEV      = 1,
   parameter int G_SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_max7219_clk,
   input  logic                   i_max7219_din,
   input  logic                   i_max7219_load,
   output logic [15:0]            o_word,
   output logic                   o_word_valid,
   output logic [16*G_NB_DEV-1:0] o_frame,
   output logic                   o_frame_valid,
   output logic [15:0]            o_bit_cnt,
   output logic                   o_err_len,
   output logic                   o_overflow
);
   localparam int FRAME_W = 16 * G_NB_DEV;
   localparam int SD      = G_SYNC_STAGES;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

   state_t             state_q;
   logic [SD:0]        sclk_q;
   logic [SD:0]        load_q;
   logic [SD-1:0]      din_q;
   logic [SD-1:0]      smp_vld_q;
   logic               armed_q;
   logic [FRAME_W-1:0] shreg_q;
   logic [FRAME_W-1:0] frame_q;
   logic [15:0]        cnt_q;
   logic [15:0]        word_q;
   logic [15:0]        bit_cnt_q;
   logic               word_valid_q;
   logic               frame_valid_q;
   logic               err_len_q;
   logic               overflow_q;

   logic               sclk_rise;
   logic               load_rise;
   logic               load_fall;
   logic               din_s;
   logic [FRAME_W-1:0] sh_base_d;
   logic [FRAME_W-1:0] sh_shift_d;
   logic [FRAME_W-1:0] sh_fin_d;
   logic [15:0]        cnt_base_d;
   logic [15:0]        cnt_inc_d;
   logic [15:0]        cnt_fin_d;
   logic               word_hit_d;
   logic               err_len_d;
   logic               overflow_d;

   // Equal depth on all inputs keeps din aligned with the serial clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_q    <= '0;
         din_q     <= '0;
         load_q    <= '1;
         smp_vld_q <= '0;
         armed_q   <= 1'b0;
      end else begin
         sclk_q    <= {sclk_q[SD-1:0], i_max7219_clk};
         din_q     <= {din_q[SD-2:0], i_max7219_din};
         load_q    <= {load_q[SD-1:0], i_max7219_load};
         smp_vld_q <= {smp_vld_q[SD-2:0], 1'b1};
         // Frames are accepted only once load has really been seen high after reset.
         if (load_q[SD-1] && smp_vld_q[SD-1]) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign sclk_rise = sclk_q[SD-1] & ~sclk_q[SD];
   assign load_rise = load_q[SD-1] & ~load_q[SD];
   assign load_fall = ~load_q[SD-1] & load_q[SD] & armed_q;
   assign din_s     = din_q[SD-1];

   always_comb begin
      sh_base_d  = shreg_q;
      cnt_base_d = cnt_q;
      if (state_q != S_SHIFT) begin
         sh_base_d  = '0;
         cnt_base_d = '0;
      end
      sh_shift_d = {sh_base_d[FRAME_W-2:0], din_s};
      cnt_inc_d  = (cnt_base_d == 16'hFFFF) ? cnt_base_d : cnt_base_d + 16'd1;
      word_hit_d = (cnt_inc_d[3:0] == 4'd0) && (cnt_inc_d != 16'd0);
      sh_fin_d   = sclk_rise ? sh_shift_d : shreg_q;
      cnt_fin_d  = sclk_rise ? cnt_inc_d : cnt_q;
      err_len_d  = (cnt_fin_d == 16'd0) || (cnt_fin_d[3:0] != 4'd0);
      overflow_d = {16'd0, cnt_fin_d} > 32'(FRAME_W);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         shreg_q       <= '0;
         cnt_q         <= '0;
         frame_q       <= '0;
         word_q        <= '0;
         bit_cnt_q     <= '0;
         word_valid_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         err_len_q     <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         word_valid_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load_fall) begin
                  state_q <= S_SHIFT;
                  // A bit arriving with the falling edge becomes bit 1 of the new frame.
                  shreg_q <= sclk_rise ? sh_shift_d : '0;
                  cnt_q   <= sclk_rise ? cnt_inc_d : 16'd0;
               end
            end
            S_SHIFT: begin
               if (sclk_rise) begin
                  shreg_q <= sh_shift_d;
                  cnt_q   <= cnt_inc_d;
                  if (word_hit_d) begin
                     word_q       <= sh_shift_d[15:0];
                     word_valid_q <= 1'b1;
                  end
               end
               if (load_rise) begin
                  state_q       <= S_LATCH;
                  frame_q       <= sh_fin_d;
                  bit_cnt_q     <= cnt_fin_d;
                  err_len_q     <= err_len_d;
                  overflow_q    <= overflow_d;
                  frame_valid_q <= 1'b1;
               end
            end
            S_LATCH: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_word        = word_q;
   assign o_word_valid  = word_valid_q;
   assign o_frame       = frame_q;
   assign o_frame_valid = frame_valid_q;
   assign o_bit_cnt     = bit_cnt_q;
   assign o_err_len     = err_len_q;
   assign o_overflow    = overflow_q;
endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: one single-device and one 8-device receiver share the serial
// lines; random frames are compared with a bit-list model of the daisy chain.
module tb_max7219_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0;
   logic din = 1'b0;
   logic load = 1'b1;

   logic [15:0]  word1, word8, bit_cnt1, bit_cnt8;
   logic         word_valid1, word_valid8, frame_valid1, frame_valid8;
   logic         err1, err8, ovf1, ovf8;
   logic [15:0]  frame1;
   logic [127:0] frame8;

   always #5 clk = ~clk;

   max7219_rx #(.G_NB_DEV(1), .G_SYNC_STAGES(2)) dut1 (
      .clk(clk), .rst(rst), .i_max7219_clk(sclk), .i_max7219_din(din),
      .i_max7219_load(load), .o_word(word1), .o_word_valid(word_valid1),
      .o_frame(frame1), .o_frame_valid(frame_valid1), .o_bit_cnt(bit_cnt1),
      .o_err_len(err1), .o_overflow(ovf1));

   max7219_rx #(.G_NB_DEV(8), .G_SYNC_STAGES(3)) dut8 (
      .clk(clk), .rst(rst), .i_max7219_clk(sclk), .i_max7219_din(din),
      .i_max7219_load(load), .o_word(word8), .o_word_valid(word_valid8),
      .o_frame(frame8), .o_frame_valid(frame_valid8), .o_bit_cnt(bit_cnt8),
      .o_err_len(err8), .o_overflow(ovf8));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse collectors; the main sequence only reads them.
   logic [15:0] w1_q[$];
   logic [15:0] w8_q[$];
   int f1_n = 0;
   int f8_n = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (word_valid1) w1_q.push_back(word1);
         if (word_valid8) w8_q.push_back(word8);
         if (frame_valid1) f1_n++;
         if (frame_valid8) f8_n++;
      end
   end

   // Reference model: list of bits in transmission order.
   bit tx[$];

   function automatic logic [127:0] exp_frame(input int w);
      logic [127:0] f;
      f = '0;
      foreach (tx[i]) f = {f[126:0], tx[i]};
      if (w < 128) f = f & ((128'd1 << w) - 128'd1);
      return f;
   endfunction

   function automatic logic [15:0] exp_word(input int k);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v = {v[14:0], tx[16*k+i]};
      return v;
   endfunction

   task automatic push_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) tx.push_back(w[i]);
   endtask

   task automatic push_rand(input int n);
      for (int i = 0; i < n; i++) tx.push_back(bit'($urandom_range(0, 1)));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int h, input bit simul);
      int n;
      n = tx.size();
      load = 1'b0;
      cyc(h);
      for (int i = 0; i < n; i++) begin
         din  = tx[i];
         sclk = 1'b0;
         cyc(h);
         sclk = 1'b1;
         if (simul && i == n - 1) load = 1'b1;
         cyc(h);
      end
      sclk = 1'b0;
      if (!(simul && n > 0)) begin
         cyc(h);
         load = 1'b1;
      end
      cyc(h + 12);
   endtask

   task automatic run(input string tag, input int h, input bit simul);
      int n, nw, f1b, f8b, w1b, w8b;
      logic exp_err;
      n = tx.size();
      nw = n / 16;
      f1b = f1_n; f8b = f8_n; w1b = w1_q.size(); w8b = w8_q.size();
      send(h, simul);
      exp_err = (n == 0) || (n % 16 != 0);
      check({tag, "/frame_pulses1"}, 128'(f1_n - f1b), 128'(1));
      check({tag, "/frame_pulses8"}, 128'(f8_n - f8b), 128'(1));
      check({tag, "/frame1"}, 128'(frame1), exp_frame(16));
      check({tag, "/frame8"}, frame8, exp_frame(128));
      check({tag, "/bit_cnt1"}, 128'(bit_cnt1), 128'(n));
      check({tag, "/bit_cnt8"}, 128'(bit_cnt8), 128'(n));
      check({tag, "/err1"}, 128'(err1), 128'(exp_err));
      check({tag, "/err8"}, 128'(err8), 128'(exp_err));
      check({tag, "/ovf1"}, 128'(ovf1), 128'(n > 16));
      check({tag, "/ovf8"}, 128'(ovf8), 128'(n > 128));
      check({tag, "/word_pulses1"}, 128'(w1_q.size() - w1b), 128'(nw));
      check({tag, "/word_pulses8"}, 128'(w8_q.size() - w8b), 128'(nw));
      for (int k = 0; k < nw; k++) begin
         if (w1b + k < w1_q.size()) check({tag, "/word1"}, 128'(w1_q[w1b+k]), 128'(exp_word(k)));
         if (w8b + k < w8_q.size()) check({tag, "/word8"}, 128'(w8_q[w8b+k]), 128'(exp_word(k)));
      end
      $display("frame %s: %0d bits, half-period %0d, simultaneous=%0d", tag, n, h, simul);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "/word1"}, 128'(word1), '0);
      check({tag, "/frame1"}, 128'(frame1), '0);
      check({tag, "/frame8"}, frame8, '0);
      check({tag, "/cnt_flags1"}, 128'({bit_cnt1, err1, ovf1, word_valid1, frame_valid1}), '0);
      check({tag, "/cnt_flags8"}, 128'({bit_cnt8, err8, ovf8, word_valid8, frame_valid8}), '0);
   endtask

   initial begin
      int f1b, f8b, w1b, w8b;
      int lens[7] = '{8, 16, 32, 48, 100, 128, 144};

      cyc(4);
      check_zero("reset");
      rst = 1'b0;
      cyc(6);

      tx.delete(); push_word(16'h0A0F);
      run("single_0A0F", 4, 1'b0);

      tx.delete();
      for (int k = 1; k <= 8; k++) push_word(16'(k * 257));
      run("chain_0101_0808", 4, 1'b0);

      tx.delete(); push_rand(20);
      run("len20", int'($urandom_range(3, 5)), 1'b0);

      tx.delete();
      run("len0", 4, 1'b0);

      // Serial clock activity while load is high must be ignored.
      f1b = f1_n; f8b = f8_n; w1b = w1_q.size(); w8b = w8_q.size();
      for (int i = 0; i < 5; i++) begin
         din = 1'b1; sclk = 1'b1; cyc(4);
         sclk = 1'b0; cyc(4);
      end
      cyc(10);
      check("idle/frame_pulses", 128'((f1_n - f1b) + (f8_n - f8b)), '0);
      check("idle/word_pulses", 128'((w1_q.size() - w1b) + (w8_q.size() - w8b)), '0);
      check("idle/bit_cnt", 128'({bit_cnt1, bit_cnt8}), '0);
      $display("idle: 5 serial clocks with load high");

      tx.delete(); push_rand(16);
      run("simul16", 3, 1'b1);
      tx.delete(); push_rand(128);
      run("simul128", 4, 1'b1);

      // Reset in the middle of a frame discards it.
      tx.delete(); push_rand(9);
      load = 1'b0; cyc(4);
      for (int i = 0; i < 9; i++) begin
         din = tx[i]; sclk = 1'b0; cyc(4);
         sclk = 1'b1; cyc(4);
      end
      sclk = 1'b0;
      rst = 1'b1; cyc(2);
      check_zero("in_reset");
      load = 1'b1; cyc(2);
      rst = 1'b0;
      f1b = f1_n; f8b = f8_n; w1b = w1_q.size(); w8b = w8_q.size();
      cyc(12);
      check_zero("after_reset");
      check("after_reset/pulses", 128'((f1_n - f1b) + (f8_n - f8b) + (w1_q.size() - w1b) + (w8_q.size() - w8b)), '0);
      $display("reset: 9-bit frame aborted");
      tx.delete(); push_word(16'h0C01);
      run("post_reset_0C01", 4, 1'b0);

      for (int r = 0; r < 6; r++) begin
         tx.delete();
         push_rand(lens[$urandom_range(0, 6)]);
         run($sformatf("rand%0d", r), int'($urandom_range(3, 5)), bit'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
